// File: rtl/ram8_arb_pkg.sv
// Shared types, width defaults and the round-robin index helper for the RAM8 arbiter.
package ram8_arb_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefAddrW = 3;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGrant  = 2'd1,
    StLocked = 2'd2
  } state_e;

  // Requester index visited `offset` steps after `base`, wrapping at n.
  function automatic int unsigned rr_index(int unsigned base, int unsigned offset,
                                           int unsigned n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/ram8_arbiter_if.sv
// Requester-side bus of the RAM8 arbiter: packed per-requester operands, grants and read return.
interface ram8_arbiter_if import ram8_arb_pkg::*; #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
);

  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        we;
  logic [N_REQ-1:0]        lock;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        gnt;
  logic [DATA_W-1:0]       rdata;
  logic [N_REQ-1:0]        rvalid;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rdata, rvalid
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rdata, rvalid
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after last_i, wrapping around.
module rr_pick import ram8_arb_pkg::*; #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IdxW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IdxW-1:0]  last_i,
  output logic [N_REQ-1:0] next_o,
  output logic [IdxW-1:0]  next_idx_o,
  output logic             valid_o
);

  logic [IdxW-1:0] idx;

  always_comb begin
    next_o     = '0;
    next_idx_o = '0;
    valid_o    = 1'b0;
    idx        = '0;
    // Offset N_REQ wraps back to last_i itself, so a lone requester can still win.
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      idx = IdxW'(rr_index(32'(last_i), off, N_REQ));
      if (!valid_o && req_i[idx]) begin
        valid_o     = 1'b1;
        next_o[idx] = 1'b1;
        next_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/ram8_arbiter.sv
// Round-robin access controller sharing one RAM8 bank between N requesters, with locked bursts.
module ram8_arbiter import ram8_arb_pkg::*; #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  ram8_arbiter_if.slave     bus,
  output logic              ram_load_o,
  output logic [ADDR_W-1:0] ram_sel_o,
  output logic [DATA_W-1:0] ram_din_o,
  input  logic [DATA_W-1:0] ram_dout_i
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CntW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_LOCK - 1);

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d, gnt, req_masked, pick_oh, rvalid_q;
  logic [IdxW-1:0]   owner_q, owner_d, last_owner_q, last_eff, pick_idx;
  logic [CntW-1:0]   lock_cnt_q, lock_cnt_d, cur_cnt;
  logic              pick_valid, grant_eff, owner_we, read_eff, lock_go;
  logic [ADDR_W-1:0] ram_sel_q;
  logic [DATA_W-1:0] ram_din_q, rdata_q;

  always_comb begin
    gnt        = gnt_q & bus.req;
    grant_eff  = |gnt;
    owner_we   = bus.we[owner_q];
    read_eff   = grant_eff & ~owner_we;
    cur_cnt    = (state_q == StLocked) ? lock_cnt_q : '0;
    lock_go    = grant_eff & bus.lock[owner_q] & (cur_cnt < CntMax);
    last_eff   = grant_eff ? owner_q : last_owner_q;
    req_masked = bus.req;
    // The holder sits out one cycle unless it keeps the lock; forced release masks it too.
    if (grant_eff && !lock_go) req_masked[owner_q] = 1'b0;
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IdxW  (IdxW)
  ) u_rr_pick (
    .req_i      (req_masked),
    .last_i     (last_eff),
    .next_o     (pick_oh),
    .next_idx_o (pick_idx),
    .valid_o    (pick_valid)
  );

  always_comb begin
    state_d    = StIdle;
    gnt_d      = '0;
    owner_d    = owner_q;
    lock_cnt_d = '0;
    if (lock_go) begin
      state_d    = StLocked;
      gnt_d      = gnt_q;
      lock_cnt_d = cur_cnt + 1'b1;
    end else if (pick_valid) begin
      state_d = StGrant;
      gnt_d   = pick_oh;
      owner_d = pick_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      gnt_q        <= '0;
      owner_q      <= '0;
      last_owner_q <= IdxW'(N_REQ - 1);
      lock_cnt_q   <= '0;
      ram_sel_q    <= '0;
      ram_din_q    <= '0;
      rdata_q      <= '0;
      rvalid_q     <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      lock_cnt_q   <= lock_cnt_d;
      last_owner_q <= last_eff;
      ram_sel_q    <= ram_sel_o;
      ram_din_q    <= ram_din_o;
      rvalid_q     <= read_eff ? gnt : '0;
      if (read_eff) rdata_q <= ram_dout_i;
    end
  end

  always_comb begin
    ram_load_o = grant_eff & owner_we;
    ram_sel_o  = grant_eff ? bus.addr[owner_q*ADDR_W +: ADDR_W] : ram_sel_q;
    ram_din_o  = grant_eff ? bus.wdata[owner_q*DATA_W +: DATA_W] : ram_din_q;
  end

  assign bus.gnt    = gnt;
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;

endmodule

// File: tb/tb_ram8_arbiter.sv
// Directed bench for ram8_arbiter with a behavioural RAM8 bank on the datapath ports.
module tb_ram8_arbiter;

  localparam int unsigned NReq = 4, DataW = 16, AddrW = 3, MaxLock = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ram_load;
  logic [AddrW-1:0] ram_sel;
  logic [DataW-1:0] ram_din, ram_dout;
  logic [DataW-1:0] mem [8];
  int               tests = 0;
  int               fails = 0;

  ram8_arbiter_if #(.N_REQ(NReq), .DATA_W(DataW), .ADDR_W(AddrW)) bus ();

  ram8_arbiter #(
    .N_REQ    (NReq),
    .DATA_W   (DataW),
    .ADDR_W   (AddrW),
    .MAX_LOCK (MaxLock)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .ram_load_o (ram_load),
    .ram_sel_o  (ram_sel),
    .ram_din_o  (ram_din),
    .ram_dout_i (ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_load) mem[ram_sel] <= ram_din;
  assign ram_dout = mem[ram_sel];

  // Inputs change 1 unit after the rising edge; outputs are checked on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.req = '0; bus.we = '0; bus.lock = '0; bus.addr = '0; bus.wdata = '0;
  endtask

  task automatic set_port(input int i, input logic [AddrW-1:0] a, input logic [DataW-1:0] d);
    bus.addr[i*AddrW +: AddrW]  = a;
    bus.wdata[i*DataW +: DataW] = d;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    idle_inputs();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    bus.req = 4'b1111; bus.we = 4'b1111;
    for (int i = 0; i < 4; i++) set_port(i, 3'(6 + i % 2), 16'(16'h5500 + i));
    step(); settle();
    tests++; if (bus.gnt !== 4'b0001) begin
      fails++; $display("FAIL rst_pre_gnt: got %b expected 0001", bus.gnt); end
    tests++; if (ram_load !== 1'b1) begin
      fails++; $display("FAIL rst_pre_load: got %b expected 1", ram_load); end
    #1 rst_n = 1'b0;
    #1;
    tests++; if (bus.gnt !== 4'b0000) begin
      fails++; $display("FAIL rst_async_gnt: got %b expected 0000", bus.gnt); end
    tests++; if (ram_load !== 1'b0) begin
      fails++; $display("FAIL rst_async_load: got %b expected 0", ram_load); end
    tests++; if (ram_sel !== 3'd0 || ram_din !== 16'h0) begin
      fails++; $display("FAIL rst_async_bus: got sel=%0d din=%h expected 0/0000", ram_sel, ram_din);
    end
    tests++; if (bus.rvalid !== 4'b0000 || bus.rdata !== 16'h0) begin
      fails++; $display("FAIL rst_async_read: got rvalid=%b rdata=%h expected 0", bus.rvalid,
                        bus.rdata);
    end
    bus.we = 4'b0000;
    step();
    rst_n = 1'b1;
    step(); settle();
    tests++; if (bus.gnt !== 4'b0001) begin
      fails++; $display("FAIL rst_first_gnt: got %b expected 0001", bus.gnt); end
  endtask

  task automatic test_contention();
    logic [3:0]  exp_g, exp_v;
    logic [15:0] exp_d;
    do_reset();
    bus.req = 4'b1111; bus.we = 4'b0000;
    for (int i = 0; i < 4; i++) set_port(i, 3'(i), 16'h0);
    for (int k = 1; k <= 5; k++) begin
      step(); settle();
      exp_g = 4'(1 << ((k - 1) % 4));
      exp_v = (k == 1) ? 4'b0000 : 4'(1 << ((k - 2) % 4));
      tests++; if (bus.gnt !== exp_g) begin
        fails++; $display("FAIL cont_gnt[%0d]: got %b expected %b", k, bus.gnt, exp_g); end
      tests++; if (bus.rvalid !== exp_v) begin
        fails++; $display("FAIL cont_rvalid[%0d]: got %b expected %b", k, bus.rvalid, exp_v); end
      if (k >= 2) begin
        exp_d = 16'(16'hA000 + (k - 2) % 4);
        tests++; if (bus.rdata !== exp_d) begin
          fails++; $display("FAIL cont_rdata[%0d]: got %h expected %h", k, bus.rdata, exp_d); end
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 4'b0100; bus.we = 4'b0100;
    set_port(2, 3'd5, 16'hBEEF);
    step(); settle();
    tests++; if (bus.gnt !== 4'b0100 || ram_load !== 1'b1) begin
      fails++; $display("FAIL single_c1: got gnt=%b load=%b expected 0100/1", bus.gnt, ram_load);
    end
    tests++; if (ram_sel !== 3'd5 || ram_din !== 16'hBEEF) begin
      fails++; $display("FAIL single_c1_bus: got sel=%0d din=%h expected 5/beef", ram_sel, ram_din);
    end
    step(); settle();
    tests++; if (bus.gnt !== 4'b0000 || ram_load !== 1'b0 || ram_sel !== 3'd5) begin
      fails++; $display("FAIL single_c2: got gnt=%b load=%b sel=%0d expected 0000/0/5", bus.gnt,
                        ram_load, ram_sel);
    end
    step(); settle();
    tests++; if (bus.gnt !== 4'b0100 || ram_load !== 1'b1) begin
      fails++; $display("FAIL single_c3: got gnt=%b load=%b expected 0100/1", bus.gnt, ram_load);
    end
    step();
    bus.we = 4'b0000;
    settle();
    tests++; if (bus.gnt !== 4'b0000) begin
      fails++; $display("FAIL single_c4: got %b expected 0000", bus.gnt); end
    step(); settle();
    tests++; if (bus.gnt !== 4'b0100 || ram_load !== 1'b0) begin
      fails++; $display("FAIL single_c5_read: got gnt=%b load=%b expected 0100/0", bus.gnt,
                        ram_load);
    end
    step(); settle();
    tests++; if (bus.rvalid !== 4'b0100 || bus.rdata !== 16'hBEEF) begin
      fails++; $display("FAIL single_c6_rdata: got rvalid=%b rdata=%h expected 0100/beef",
                        bus.rvalid, bus.rdata);
    end
  endtask

  task automatic test_lock();
    do_reset();
    bus.req = 4'b0010; bus.lock = 4'b0010;
    for (int k = 1; k <= 4; k++) begin
      step();
      bus.req = 4'b0011;
      settle();
      tests++; if (bus.gnt !== 4'b0010) begin
        fails++; $display("FAIL lock_gnt[%0d]: got %b expected 0010", k, bus.gnt); end
    end
    step(); settle();
    tests++; if (bus.gnt !== 4'b0001) begin
      fails++; $display("FAIL lock_release: got %b expected 0001", bus.gnt); end
    step(); settle();
    tests++; if (bus.gnt !== 4'b0010) begin
      fails++; $display("FAIL lock_regrant: got %b expected 0010", bus.gnt); end
  endtask

  task automatic test_withdraw();
    do_reset();
    bus.req = 4'b1000; bus.we = 4'b1000;
    set_port(3, 3'd4, 16'h0BAD);
    step();
    bus.req = 4'b0000;
    settle();
    tests++; if (bus.gnt !== 4'b0000 || ram_load !== 1'b0) begin
      fails++; $display("FAIL withdraw_idle: got gnt=%b load=%b expected 0000/0", bus.gnt,
                        ram_load);
    end
    step();
    bus.req = 4'b1111; bus.we = 4'b0000;
    settle();
    tests++; if (bus.gnt !== 4'b0000 || bus.rvalid !== 4'b0000) begin
      fails++; $display("FAIL withdraw_next: got gnt=%b rvalid=%b expected 0000/0000", bus.gnt,
                        bus.rvalid);
    end
    step(); settle();
    tests++; if (bus.gnt !== 4'b0001) begin
      fails++; $display("FAIL withdraw_prio: got %b expected 0001", bus.gnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.req = 4'b0001; bus.lock = 4'b0001; bus.we = 4'b0001;
    set_port(0, 3'd2, 16'h1234);
    step(); settle();
    tests++; if (bus.gnt !== 4'b0001 || ram_load !== 1'b1 || ram_sel !== 3'd2) begin
      fails++; $display("FAIL raw_write: got gnt=%b load=%b sel=%0d expected 0001/1/2", bus.gnt,
                        ram_load, ram_sel);
    end
    step();
    bus.we = 4'b0000; bus.lock = 4'b0000;
    settle();
    tests++; if (bus.gnt !== 4'b0001 || ram_load !== 1'b0) begin
      fails++; $display("FAIL raw_read_gnt: got gnt=%b load=%b expected 0001/0", bus.gnt,
                        ram_load);
    end
    step(); settle();
    tests++; if (bus.rvalid !== 4'b0001 || bus.rdata !== 16'h1234) begin
      fails++; $display("FAIL raw_rdata: got rvalid=%b rdata=%h expected 0001/1234", bus.rvalid,
                        bus.rdata);
    end
    tests++; if (bus.gnt !== 4'b0000) begin
      fails++; $display("FAIL raw_masked: got %b expected 0000", bus.gnt); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 16'(16'hA000 + i);
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_contention();
    test_single();
    test_lock();
    test_withdraw();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
